// File: rtl/cm0_dap_cdc_rx_slave.sv
// Destination (DCLK) end of the DAP four-phase request/acknowledge CDC link.
// Synchronises REQ, captures the source bus, and presents it as a valid/ready transfer.
module cm0_dap_cdc_rx_slave #(
  parameter int PRESENT     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 32
) (
  input  logic          DCLK,
  input  logic          DRESETn,
  input  logic          REQ_ASYNC,
  input  logic [3:0]    ADDRIN,
  input  logic          RNWIN,
  input  logic [DW-1:0] WDATAIN,
  output logic          ACK,
  output logic [DW-1:0] RDATA,
  output logic          XFR_VALID,
  output logic [3:0]    XFR_ADDR,
  output logic          XFR_RNW,
  output logic [DW-1:0] XFR_WDATA,
  input  logic          XFR_READY,
  input  logic [DW-1:0] XFR_RDATA,
  output logic          ABORTED
);

  generate
    if (PRESENT != 0) begin : g_present
      typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACKH  = 2'd2,
        ST_WAITL = 2'd3
      } state_t;

      state_t                 state_q, state_d;
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   req_s;
      logic                   ack_q, ack_d;
      logic [DW-1:0]          rdata_q, rdata_d;
      logic                   xfr_valid_q, xfr_valid_d;
      logic [3:0]             xfr_addr_q, xfr_addr_d;
      logic                   xfr_rnw_q, xfr_rnw_d;
      logic [DW-1:0]          xfr_wdata_q, xfr_wdata_d;
      logic                   aborted_q, aborted_d;

      assign req_s = sync_q[SYNC_STAGES-1];

      // Next-state and next-output logic; ADDRIN/RNWIN/WDATAIN are only looked at once req_s=1.
      always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
        state_d     = state_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        xfr_valid_d = xfr_valid_q;
        xfr_addr_d  = xfr_addr_q;
        xfr_rnw_d   = xfr_rnw_q;
        xfr_wdata_d = xfr_wdata_q;
        aborted_d   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (req_s) begin
              xfr_addr_d  = ADDRIN;
              xfr_rnw_d   = RNWIN;
              xfr_wdata_d = WDATAIN;
              xfr_valid_d = 1'b1;
              state_d     = ST_VALID;
            end else begin
              state_d     = ST_IDLE;
            end
          end
          ST_VALID: begin
            // Acceptance wins over a simultaneous request withdrawal.
            if (XFR_READY) begin
              xfr_valid_d = 1'b0;
              rdata_d     = xfr_rnw_q ? XFR_RDATA : {DW{1'b0}};
              ack_d       = 1'b1;
              state_d     = ST_ACKH;
            end else if (!req_s) begin
              xfr_valid_d = 1'b0;
              aborted_d   = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d     = ST_VALID;
            end
          end
          ST_ACKH: begin
            if (!req_s) begin
              ack_d   = 1'b0;
              rdata_d = {DW{1'b0}};
              state_d = ST_WAITL;
            end else begin
              state_d = ST_ACKH;
            end
          end
          ST_WAITL: begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            ack_d       = 1'b0;
            rdata_d     = {DW{1'b0}};
            xfr_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        endcase
      end

      // All state, including the request synchroniser, with synchronous reset.
      always_ff @(posedge DCLK) begin
        if (!DRESETn) begin
          sync_q      <= {SYNC_STAGES{1'b0}};
          state_q     <= ST_IDLE;
          ack_q       <= 1'b0;
          rdata_q     <= {DW{1'b0}};
          xfr_valid_q <= 1'b0;
          xfr_addr_q  <= 4'h0;
          xfr_rnw_q   <= 1'b0;
          xfr_wdata_q <= {DW{1'b0}};
          aborted_q   <= 1'b0;
        end else begin
          sync_q      <= sync_d;
          state_q     <= state_d;
          ack_q       <= ack_d;
          rdata_q     <= rdata_d;
          xfr_valid_q <= xfr_valid_d;
          xfr_addr_q  <= xfr_addr_d;
          xfr_rnw_q   <= xfr_rnw_d;
          xfr_wdata_q <= xfr_wdata_d;
          aborted_q   <= aborted_d;
        end
      end

      assign ACK       = ack_q;
      assign RDATA     = rdata_q;
      assign XFR_VALID = xfr_valid_q;
      assign XFR_ADDR  = xfr_addr_q;
      assign XFR_RNW   = xfr_rnw_q;
      assign XFR_WDATA = xfr_wdata_q;
      assign ABORTED   = aborted_q;
    end else begin : g_absent
      logic unused_s;
      assign unused_s  = ^{DCLK, DRESETn, REQ_ASYNC, ADDRIN, RNWIN, WDATAIN, XFR_READY, XFR_RDATA};
      assign ACK       = 1'b0;
      assign RDATA     = {DW{1'b0}};
      assign XFR_VALID = 1'b0;
      assign XFR_ADDR  = 4'h0;
      assign XFR_RNW   = 1'b0;
      assign XFR_WDATA = {DW{1'b0}};
      assign ABORTED   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_rx_slave.sv
// Self-checking bench for cm0_dap_cdc_rx_slave: scoreboarded captures, handshake timing,
// abort, reset mid-transfer, plus PRESENT=0 and SYNC_STAGES=3 variants.
module tb_cm0_dap_cdc_rx_slave;

  typedef struct {
    logic [3:0]  addr;
    logic        rnw;
    logic [31:0] wdata;
  } xfer_t;

  logic        dclk;
  logic        dresetn;
  logic        req_async;
  logic [3:0]  addrin;
  logic        rnwin;
  logic [31:0] wdatain;
  logic        xfr_ready;
  logic [31:0] xfr_rdata;

  logic        ack, xfr_valid, xfr_rnw, aborted;
  logic [31:0] rdata, xfr_wdata;
  logic [3:0]  xfr_addr;

  logic        np_ack, np_xfr_valid, np_xfr_rnw, np_aborted;
  logic [31:0] np_rdata, np_xfr_wdata;
  logic [3:0]  np_xfr_addr;

  logic        s3_ready;
  logic        s3_ack, s3_xfr_valid, s3_xfr_rnw, s3_aborted;
  logic [31:0] s3_rdata, s3_xfr_wdata;
  logic [3:0]  s3_xfr_addr;

  int n_cmp = 0;
  int n_err = 0;
  xfer_t exp_q[$];

  cm0_dap_cdc_rx_slave #(.PRESENT(1), .SYNC_STAGES(2), .DW(32)) dut (
    .DCLK(dclk), .DRESETn(dresetn), .REQ_ASYNC(req_async), .ADDRIN(addrin), .RNWIN(rnwin),
    .WDATAIN(wdatain), .ACK(ack), .RDATA(rdata), .XFR_VALID(xfr_valid), .XFR_ADDR(xfr_addr),
    .XFR_RNW(xfr_rnw), .XFR_WDATA(xfr_wdata), .XFR_READY(xfr_ready), .XFR_RDATA(xfr_rdata),
    .ABORTED(aborted)
  );

  cm0_dap_cdc_rx_slave #(.PRESENT(0), .SYNC_STAGES(2), .DW(32)) dut_np (
    .DCLK(dclk), .DRESETn(dresetn), .REQ_ASYNC(req_async), .ADDRIN(addrin), .RNWIN(rnwin),
    .WDATAIN(wdatain), .ACK(np_ack), .RDATA(np_rdata), .XFR_VALID(np_xfr_valid),
    .XFR_ADDR(np_xfr_addr), .XFR_RNW(np_xfr_rnw), .XFR_WDATA(np_xfr_wdata),
    .XFR_READY(xfr_ready), .XFR_RDATA(xfr_rdata), .ABORTED(np_aborted)
  );

  cm0_dap_cdc_rx_slave #(.PRESENT(1), .SYNC_STAGES(3), .DW(32)) dut_s3 (
    .DCLK(dclk), .DRESETn(dresetn), .REQ_ASYNC(req_async), .ADDRIN(addrin), .RNWIN(rnwin),
    .WDATAIN(wdatain), .ACK(s3_ack), .RDATA(s3_rdata), .XFR_VALID(s3_xfr_valid),
    .XFR_ADDR(s3_xfr_addr), .XFR_RNW(s3_xfr_rnw), .XFR_WDATA(s3_xfr_wdata),
    .XFR_READY(s3_ready), .XFR_RDATA(xfr_rdata), .ABORTED(s3_aborted)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic start_req(input logic [3:0] a, input logic r, input logic [31:0] w);
    xfer_t e;
    e.addr = a; e.rnw = r; e.wdata = w;
    exp_q.push_back(e);
    addrin = a; rnwin = r; wdatain = w;
    req_async = 1'b1;
  endtask

  // Ticks until XFR_VALID (bounded), checks the latency and pops the scoreboard.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    xfer_t e;
    n = 0;
    while (xfr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, 128'(n), 128'(exp_lat));
    if (xfr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_sb_empty"}, 128'(0), 128'(1));
      end else begin
        e = exp_q.pop_front();
        check_val({tag, "_addr"}, 128'(xfr_addr), 128'(e.addr));
        check_val({tag, "_rnw"}, 128'(xfr_rnw), 128'(e.rnw));
        check_val({tag, "_wdata"}, 128'(xfr_wdata), 128'(e.wdata));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dresetn = 1'b0; req_async = 1'b0; addrin = 4'h0; rnwin = 1'b0; wdatain = 32'h0;
    xfr_ready = 1'b0; xfr_rdata = 32'h0; s3_ready = 1'b1;
    tick(2);
    check_val("rst_out", {ack, rdata, xfr_valid, xfr_addr, xfr_rnw, xfr_wdata, aborted}, 128'h0);
    check_val("rst_s3", {s3_ack, s3_xfr_valid, s3_xfr_addr}, 128'h0);
    dresetn = 1'b1;
    tick(2);

    // 1: write, ready already high
    xfr_ready = 1'b1;
    start_req(4'hA, 1'b0, 32'h1234_5678);
    wait_valid("t1", 3);
    check_val("t1_s3_notyet", 128'(s3_xfr_valid), 128'h0);
    tick();
    check_val("t1_ack", 128'(ack), 128'h1);
    check_val("t1_valid_clr", 128'(xfr_valid), 128'h0);
    check_val("t1_rdata", 128'(rdata), 128'h0);
    check_val("t1_s3_valid", 128'(s3_xfr_valid), 128'h1);
    check_val("t1_s3_addr", 128'(s3_xfr_addr), 128'hA);
    req_async = 1'b0;
    tick(2);
    check_val("t1_ack_hold", 128'(ack), 128'h1);
    tick();
    check_val("t1_ack_fall", 128'(ack), 128'h0);
    tick(8);

    // 2: read with 5 cycles of backpressure
    xfr_ready = 1'b0;
    xfr_rdata = 32'h1111_2222;
    start_req(4'h3, 1'b1, 32'h0BAD_0BAD);
    wait_valid("t2", 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t2_valid_held", 128'(xfr_valid), 128'h1);
      check_val("t2_no_ack", 128'(ack), 128'h0);
    end
    xfr_ready = 1'b1;
    xfr_rdata = 32'hDEAD_BEEF;
    tick();
    check_val("t2_ack", 128'(ack), 128'h1);
    check_val("t2_rdata", 128'(rdata), 128'hDEAD_BEEF);
    check_val("t2_valid_clr", 128'(xfr_valid), 128'h0);
    xfr_ready = 1'b0;
    xfr_rdata = 32'h5555_AAAA;
    tick(2);
    check_val("t2_rdata_hold", 128'(rdata), 128'hDEAD_BEEF);
    req_async = 1'b0;
    tick(2);
    check_val("t2_rdata_hold2", 128'(rdata), 128'hDEAD_BEEF);
    tick();
    check_val("t2_ack_fall", 128'(ack), 128'h0);
    check_val("t2_rdata_zero", 128'(rdata), 128'h0);
    tick(8);

    // 3: abort before acceptance
    start_req(4'h5, 1'b0, 32'hA5A5_5A5A);
    wait_valid("t3", 3);
    req_async = 1'b0;
    tick(2);
    check_val("t3_valid_still", 128'(xfr_valid), 128'h1);
    check_val("t3_no_abort_yet", 128'(aborted), 128'h0);
    tick();
    check_val("t3_aborted", 128'(aborted), 128'h1);
    check_val("t3_valid_clr", 128'(xfr_valid), 128'h0);
    check_val("t3_ack", 128'(ack), 128'h0);
    tick();
    check_val("t3_abort_pulse", 128'(aborted), 128'h0);
    check_val("t3_addr_held", 128'(xfr_addr), 128'h5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t3_ack_never", {ack, xfr_valid}, 128'h0);
    end

    // 4: req_s falls in the cycle XFR_READY rises
    xfr_rdata = 32'hCAFE_F00D;
    start_req(4'h9, 1'b1, 32'h0);
    wait_valid("t4", 3);
    req_async = 1'b0;
    tick(2);
    xfr_ready = 1'b1;
    tick();
    check_val("t4_ack", 128'(ack), 128'h1);
    check_val("t4_no_abort", 128'(aborted), 128'h0);
    check_val("t4_rdata", 128'(rdata), 128'hCAFE_F00D);
    xfr_ready = 1'b0;
    tick();
    check_val("t4_ack_fall", 128'(ack), 128'h0);
    check_val("t4_rdata_zero", 128'(rdata), 128'h0);
    tick(8);

    // 5: reset while ACK is high, REQ stays high
    xfr_ready = 1'b1;
    start_req(4'h7, 1'b0, 32'h7777_0001);
    wait_valid("t5a", 3);
    tick();
    check_val("t5_ack", 128'(ack), 128'h1);
    dresetn = 1'b0;
    tick();
    check_val("t5_rst", {ack, rdata, xfr_valid}, 128'h0);
    dresetn = 1'b1;
    start_req(4'h7, 1'b0, 32'h7777_0001);
    wait_valid("t5b", 3);
    tick();
    check_val("t5_ack2", 128'(ack), 128'h1);
    req_async = 1'b0;
    tick(3);
    check_val("t5_ack_fall", 128'(ack), 128'h0);
    tick(8);
    check_val("sb_drained", 128'(exp_q.size()), 128'h0);

    // 6: PRESENT=0 build stays silent under random stimulus
    for (int i = 0; i < 30; i++) begin
      req_async = 1'($urandom_range(0, 1));
      addrin    = 4'($urandom_range(0, 15));
      rnwin     = 1'($urandom_range(0, 1));
      wdatain   = $urandom;
      xfr_ready = 1'($urandom_range(0, 1));
      xfr_rdata = $urandom;
      tick();
      check_val("np_out", {np_ack, np_rdata, np_xfr_valid, np_xfr_addr, np_xfr_rnw, np_xfr_wdata,
                           np_aborted}, 128'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
